// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a valid/ready request and result handshake.
// Logic, add/sub and shift operations finish one cycle after accept.
// MUL and DIV use an iterative engine that runs SIZE cycles and
// always takes the full SIZE cycles, including for divide-by-zero.
module alu_multicycle #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] op1,
    input  logic [SIZE-1:0] op2,
    input  logic [3:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] result,
    output logic            zero,
    output logic            ovf,
    output logic            dbz
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // BUSY  | MUL/DIV engine iterating, r_cnt counts down to 0
    // DONE  | result presented, held until out_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_SRL  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRA  = 4'b0010;
    localparam logic [3:0] OP_SLLV = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_DIV  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;

    localparam int CW  = $clog2(SIZE);
    localparam int SHW = $clog2(SIZE);
    localparam int MSB = SIZE - 1;

    localparam logic [CW-1:0]   C_CNT_LOAD = CW'(SIZE - 1);
    localparam logic [63:0]     C_SIZE64   = 64'(SIZE);
    localparam logic [SIZE-1:0] C_MOST_NEG = {1'b1, {(SIZE-1){1'b0}}};

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;

    logic [2*SIZE-1:0] r_acc;
    logic [2*SIZE-1:0] r_mcand;
    logic [SIZE-1:0]   r_mplier;

    logic [SIZE-1:0]   r_rem;
    logic [SIZE-1:0]   r_quo;
    logic [SIZE-1:0]   r_divisor;
    logic              r_q_neg;
    logic              r_div_dbz;
    logic              r_div_ovf;

    logic [SIZE-1:0]   r_result;
    logic              r_zero;
    logic              r_ovf;
    logic              r_dbz;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_is_long;
    logic              w_shamt_big;
    logic [SHW-1:0]    w_shamt;
    logic [SIZE-1:0]   w_sum;
    logic [SIZE-1:0]   w_diff;
    logic [SIZE-1:0]   w_srl;
    logic [SIZE-1:0]   w_sra;
    logic [SIZE-1:0]   w_sll;
    logic [SIZE-1:0]   w_sll_back;
    logic [SIZE-1:0]   w_sc_res;
    logic              w_sc_ovf;

    logic              w_last;
    logic [2*SIZE-1:0] w_mul_addend;
    logic [2*SIZE-1:0] w_acc_next;
    logic              w_mul_ovf;

    logic [SIZE:0]     w_rem_sh;
    logic              w_rem_ge;
    logic [SIZE-1:0]   w_rem_sub;
    logic [SIZE-1:0]   w_rem_next;
    logic [SIZE-1:0]   w_quo_next;
    logic [SIZE-1:0]   w_div_res;
    logic [SIZE-1:0]   w_abs1;
    logic [SIZE-1:0]   w_abs2;

    logic [SIZE-1:0]   w_fin_res;
    logic              w_fin_ovf;
    logic              w_fin_dbz;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_is_mul  = (alu_op == OP_MUL);
    assign w_is_div  = (alu_op == OP_DIV);
    assign w_is_long = w_is_mul || w_is_div;

    // Shift amount is op2 as unsigned; anything >= SIZE saturates.
    assign w_shamt_big = (64'(op2) >= C_SIZE64);
    assign w_shamt     = op2[SHW-1:0];

    assign w_sum      = op1 + op2;
    assign w_diff     = op1 - op2;
    assign w_srl      = op1 >> w_shamt;
    assign w_sra      = $unsigned($signed(op1) >>> w_shamt);
    assign w_sll      = op1 << w_shamt;
    // Shifting back arithmetically recovers op1 only when every bit
    // pushed out, and the new sign bit, matched the original sign.
    assign w_sll_back = $unsigned($signed(w_sll) >>> w_shamt);

    // Single-cycle datapath, evaluated straight from the request inputs
    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        case (alu_op)
            OP_AND:  w_sc_res = op1 & op2;
            OP_OR:   w_sc_res = op1 | op2;
            OP_NOR:  w_sc_res = ~(op1 | op2);
            OP_NAND: w_sc_res = ~(op1 & op2);
            OP_XOR:  w_sc_res = op1 ^ op2;
            OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (op1[MSB] == op2[MSB]) && (w_sum[MSB] != op1[MSB]);
            end
            OP_SUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (op1[MSB] != op2[MSB]) && (w_diff[MSB] != op1[MSB]);
            end
            OP_SRL:  w_sc_res = w_shamt_big ? '0 : w_srl;
            OP_SRA:  w_sc_res = w_shamt_big ? {SIZE{op1[MSB]}} : w_sra;
            OP_SLL, OP_SLLV: begin
                if (w_shamt_big) begin
                    w_sc_res = '0;
                    w_sc_ovf = |op1;
                end else begin
                    w_sc_res = w_sll;
                    w_sc_ovf = (w_sll_back != op1);
                end
            end
            OP_MUL, OP_DIV: begin
                w_sc_res = '0;
                w_sc_ovf = 1'b0;
            end
            default: begin
                w_sc_res = '0;
                w_sc_ovf = 1'b1;
            end
        endcase
    end

    assign w_last = (r_cnt == '0);

    // Radix-2 shift-add: the final step weighs the multiplier sign bit
    // by -2^(SIZE-1), which makes the 2*SIZE product signed-correct.
    assign w_mul_addend = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next   = w_last ? (r_acc - w_mul_addend) : (r_acc + w_mul_addend);
    assign w_mul_ovf    = (w_acc_next[2*SIZE-1:SIZE] != {SIZE{w_acc_next[MSB]}});

    // Restoring division on magnitudes; sign applied at the end so the
    // quotient truncates toward zero.
    assign w_abs1     = op1[MSB] ? -op1 : op1;
    assign w_abs2     = op2[MSB] ? -op2 : op2;
    assign w_rem_sh   = {r_rem, r_quo[MSB]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_sub  = w_rem_sh[SIZE-1:0] - r_divisor;
    assign w_rem_next = w_rem_ge ? w_rem_sub : w_rem_sh[SIZE-1:0];
    assign w_quo_next = {r_quo[SIZE-2:0], w_rem_ge};
    assign w_div_res  = r_div_dbz ? '0 : (r_q_neg ? -w_quo_next : w_quo_next);

    assign w_fin_res = r_is_div ? w_div_res : w_acc_next[SIZE-1:0];
    assign w_fin_ovf = r_is_div ? r_div_ovf : w_mul_ovf;
    assign w_fin_dbz = r_is_div && r_div_dbz;

    // Control FSM and iteration down-counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_long) begin
                            r_state <= S_BUSY;
                            r_cnt   <= C_CNT_LOAD;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Iterative engine: operands captured on accept, stepped while BUSY
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_div  <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_q_neg   <= 1'b0;
            r_div_dbz <= 1'b0;
            r_div_ovf <= 1'b0;
        end else if (w_accept && w_is_long) begin
            r_is_div  <= w_is_div;
            r_acc     <= '0;
            r_mcand   <= {{SIZE{op1[MSB]}}, op1};
            r_mplier  <= op2;
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_divisor <= w_abs2;
            r_q_neg   <= op1[MSB] ^ op2[MSB];
            r_div_dbz <= (op2 == '0);
            r_div_ovf <= (op1 == C_MOST_NEG) && (&op2);
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_rem_next;
            r_quo    <= w_quo_next;
        end
    end

    // Output registers, written once per operation and held through DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_accept && !w_is_long) begin
            r_result <= w_sc_res;
            r_zero   <= (w_sc_res == '0);
            r_ovf    <= w_sc_ovf;
            r_dbz    <= 1'b0;
        end else if ((r_state == S_BUSY) && w_last) begin
            r_result <= w_fin_res;
            r_zero   <= (w_fin_res == '0);
            r_ovf    <= w_fin_ovf;
            r_dbz    <= w_fin_dbz;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: a 32-bit instance driven by a
// vector table, random stimulus against an arithmetic model, and
// handshake/reset sequences; an 8-bit instance for narrow corner cases.
module tb_alu_multicycle;

    localparam logic [3:0] SRL  = 4'b0000, SLL = 4'b0001, SRA = 4'b0010, SLLV = 4'b0011;
    localparam logic [3:0] ADD  = 4'b0100, SUB = 4'b0101, MUL = 4'b0110, DIV  = 4'b0111;
    localparam logic [3:0] LAND = 4'b1000, LOR = 4'b1001, LNOR = 4'b1010, LNAND = 4'b1011;
    localparam logic [3:0] LXOR = 4'b1100;

    localparam longint MIN32 = -64'sd2147483648;
    localparam longint MAX32 = 64'sd2147483647;

    logic        clk = 1'b0;
    logic        resetn;

    logic        in_valid, in_ready, out_valid, out_ready, zero, ovf, dbz;
    logic [31:0] op1, op2, result;
    logic [3:0]  alu_op;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_zero, e_ovf, e_dbz;
    logic [7:0]  e_op1, e_op2, e_result;
    logic [3:0]  e_alu_op;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vt[20];

    always #5 clk = ~clk;

    alu_multicycle #(.SIZE(32)) dut32 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf), .dbz(dbz)
    );

    alu_multicycle #(.SIZE(8)) dut8 (
        .clk(clk), .resetn(resetn),
        .in_valid(e_in_valid), .in_ready(e_in_ready),
        .op1(e_op1), .op2(e_op2), .alu_op(e_alu_op),
        .out_valid(e_out_valid), .out_ready(e_out_ready),
        .result(e_result), .zero(e_zero), .ovf(e_ovf), .dbz(e_dbz)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: true signed arithmetic on 64-bit values, then range tests.
    task automatic model32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic ov, output logic dz, output int lat);
        longint sa, sb, ub, full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'(b);
        r = '0; ov = 1'b0; dz = 1'b0; full = 0;
        lat = (op == MUL || op == DIV) ? 33 : 1;
        case (op)
            LAND:  r = a & b;
            LOR:   r = a | b;
            LNOR:  r = ~(a | b);
            LNAND: r = ~(a & b);
            LXOR:  r = a ^ b;
            ADD, SUB, MUL: begin
                full = (op == ADD) ? sa + sb : (op == SUB) ? sa - sb : sa * sb;
                r = full[31:0];
                ov = (full < MIN32) || (full > MAX32);
            end
            DIV: begin
                if (sb == 0) dz = 1'b1;
                else if (sa == MIN32 && sb == -1) begin r = a; ov = 1'b1; end
                else begin full = sa / sb; r = full[31:0]; end
            end
            SRL: r = (ub >= 32) ? 32'd0 : a >> ub;
            SRA: begin
                full = sa >>> ((ub >= 32) ? 63 : ub);
                r = full[31:0];
            end
            SLL, SLLV: begin
                if (ub >= 32) ov = (a != 0);
                else begin
                    full = sa <<< ub;
                    r = full[31:0];
                    ov = (full < MIN32) || (full > MAX32);
                end
            end
            default: ov = 1'b1;
        endcase
    endtask

    // One request/response on the 32-bit instance. After accept the inputs
    // are scrambled with in_valid still high; the DUT must ignore them.
    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ov, output logic z,
                         output logic dz, output int lat, output logic busy_rdy);
        busy_rdy = 1'b0;
        in_valid = 1'b1; alu_op = op; op1 = a; op2 = b; out_ready = 1'b0;
        @(posedge clk); #1;
        op1 = $urandom; op2 = $urandom; alu_op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_rdy = 1'b1;
        r = result; ov = ovf; z = zero; dz = dbz;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("release_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic apply32(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic eov,
                           input logic edz, input int elat);
        logic [31:0] r;
        logic ov, z, dz, br;
        int lat;
        run32(op, a, b, r, ov, z, dz, lat, br);
        check({tag, ".result"}, {32'd0, r}, {32'd0, er});
        check({tag, ".ovf"}, {63'd0, ov}, {63'd0, eov});
        check({tag, ".zero"}, {63'd0, z}, {63'd0, (er == 32'd0)});
        check({tag, ".dbz"}, {63'd0, dz}, {63'd0, edz});
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".in_ready_busy"}, {63'd0, br}, 64'd0);
    endtask

    task automatic apply8(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic eov,
                          input logic edz, input int elat);
        int lat;
        e_in_valid = 1'b1; e_alu_op = op; e_op1 = a; e_op2 = b; e_out_ready = 1'b0;
        @(posedge clk); #1;
        e_op1 = 8'($urandom); e_op2 = 8'($urandom);
        lat = 1;
        while (!e_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".result"}, {56'd0, e_result}, {56'd0, er});
        check({tag, ".ovf"}, {63'd0, e_ovf}, {63'd0, eov});
        check({tag, ".zero"}, {63'd0, e_zero}, {63'd0, (er == 8'd0)});
        check({tag, ".dbz"}, {63'd0, e_dbz}, {63'd0, edz});
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        e_out_ready = 1'b1;
        @(posedge clk); #1;
        e_in_valid = 1'b0; e_out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'd0;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h7FFFFFFF;
            4: begin v = $urandom_range(0, 20); v = v - 32'd10; end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, er;
        logic [3:0]  rop;
        logic        eov, edz, seen;
        int          elat;

        vt[0]  = '{ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1};
        vt[1]  = '{MUL,   32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0, 1'b0, 33};
        vt[2]  = '{DIV,   32'h00000007, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 33};
        vt[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 33};
        vt[4]  = '{SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        vt[5]  = '{LAND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
        vt[6]  = '{LOR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1};
        vt[7]  = '{LNOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vt[8]  = '{LNAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1};
        vt[9]  = '{LXOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0, 1};
        vt[10] = '{SRL,   32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 1};
        vt[11] = '{SRA,   32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1};
        vt[12] = '{SRA,   32'h80000000, 32'd32,       32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vt[13] = '{SLL,   32'h00000001, 32'd32,       32'h00000000, 1'b1, 1'b0, 1};
        vt[14] = '{SLLV,  32'h00000001, 32'd4,        32'h00000010, 1'b0, 1'b0, 1};
        vt[15] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 33};
        vt[16] = '{MUL,   32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 33};
        vt[17] = '{4'b1101, 32'h12345678, 32'h1,      32'h00000000, 1'b1, 1'b0, 1};
        vt[18] = '{SRL,   32'hFFFFFFFF, 32'h00000100, 32'h00000000, 1'b0, 1'b0, 1};
        vt[19] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 33};

        resetn = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0; alu_op = '0;
        e_in_valid = 1'b0; e_out_ready = 1'b0; e_op1 = '0; e_op2 = '0; e_alu_op = '0;

        #12;
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.result", {32'd0, result}, 64'd0);
        check("rst.flags", {61'd0, zero, ovf, dbz}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 20; i++)
            apply32($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                    vt[i].res, vt[i].ov, vt[i].dz, vt[i].lat);

        // Result held for 5 cycles of back-pressure, IDLE right after release
        in_valid = 1'b1; alu_op = SUB; op1 = 32'd5; op2 = 32'd5; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d.out_valid", k), {63'd0, out_valid}, 64'd1);
            check($sformatf("hold%0d.result", k), {32'd0, result}, 64'd0);
            check($sformatf("hold%0d.zero", k), {63'd0, zero}, 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold.release_in_ready", {63'd0, in_ready}, 64'd1);
        check("hold.release_out_valid", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of a MUL abandons it
        apply32("pre_rst", LOR, 32'h00001234, 32'h0, 32'h00001234, 1'b0, 1'b0, 1);
        in_valid = 1'b1; alu_op = MUL; op1 = 32'hFFFFFFFD; op2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst.out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst.result", {32'd0, result}, 64'd0);
        check("midrst.flags", {61'd0, zero, ovf, dbz}, 64'd0);
        check("midrst.in_ready", {63'd0, in_ready}, 64'd1);
        #2;
        resetn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst.no_out_valid", {63'd0, seen}, 64'd0);
        apply32("post_rst_add", ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

        // Narrow instance
        apply8("sra8_big",  SRA,     8'h90, 8'd20, 8'hFF, 1'b0, 1'b0, 1);
        apply8("sll8_sign", SLL,     8'h40, 8'd1,  8'h80, 1'b1, 1'b0, 1);
        apply8("ill8",      4'b1111, 8'h55, 8'h0F, 8'h00, 1'b1, 1'b0, 1);
        apply8("srl8_eq",   SRL,     8'h80, 8'd8,  8'h00, 1'b0, 1'b0, 1);
        apply8("sll8_ok",   SLL,     8'hFF, 8'd3,  8'hF8, 1'b0, 1'b0, 1);
        apply8("mul8_ovf",  MUL,     8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 9);
        apply8("mul8_neg",  MUL,     8'hFD, 8'h07, 8'hEB, 1'b0, 1'b0, 9);
        apply8("div8_ovf",  DIV,     8'h80, 8'hFF, 8'h80, 1'b1, 1'b0, 9);
        apply8("div8_neg",  DIV,     8'h64, 8'hF9, 8'hF2, 1'b0, 1'b0, 9);
        apply8("div8_zero", DIV,     8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 9);

        // Random stimulus against the arithmetic model
        for (int n = 0; n < 300; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            if (rop <= SLLV && $urandom_range(0, 1) == 1) rb = $urandom_range(0, 40);
            model32(rop, ra, rb, er, eov, edz, elat);
            apply32($sformatf("rnd%0d_op%0h", n, rop), rop, ra, rb, er, eov, edz, elat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
